measure_sequencer: RTL

MEASURE_SEQUENCER -- requirements
Module: measure_sequencer

---
 rtl/freq_counter_pkg.sv | 28 ++
 rtl/measure_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency-counter measurement sequencer:
// sequencer state encoding and the gate-length table indexed by range select.
package freq_counter_pkg;

    localparam int GATE_W = 20;

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_GATE      = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_LATCH     = 3'd3,
        ST_REFRESH   = 3'd4,
        ST_HOLDOFF   = 3'd5,
        ST_WAIT_DONE = 3'd6,
        ST_FROZEN    = 3'd7
    } state_t;

    // Gate length in reference-clock cycles for each range select value.
    localparam logic [GATE_W-1:0] GATE_CYCLES [4] = '{
        20'd1000, 20'd10000, 20'd100000, 20'd1000000
    };

    // Gate timer preload: the timer counts N-1 down to 0, giving N gate cycles.
    function automatic logic [GATE_W-1:0] gate_load(input logic [1:0] range_sel);
        return GATE_CYCLES[range_sel] - GATE_W'(1);
    endfunction

endpackage

// File: rtl/measure_sequencer.sv
// Measurement sequencer for a gated BCD frequency counter: clears the
// counter, opens the gate for the selected time, lets the count settle,
// latches the digits and hands the result to the display streamer.
// Every output is a register whose next value is derived from the next state,
// so outputs change exactly with the state they belong to.
module measure_sequencer
    import freq_counter_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [1:0] range_sel_in,
    input  logic       hold_in,
    input  logic       overflow_in,
    input  logic       streamer_ready_in,
    output logic       cnt_reset_out,
    output logic       cnt_enable_out,
    output logic       latch_stb_out,
    output logic       refresh_stb_out,
    output logic [1:0] range_out,
    output logic       overflow_out
);

    localparam int PHASE_W = 16;
    localparam logic [PHASE_W-1:0] CLEAR_LOAD   = PHASE_W'(CLEAR_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SETTLE_LOAD  = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLDOFF_LOAD = PHASE_W'(HOLDOFF_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [1:0]          range_q, range_d;
    logic                sticky_q, sticky_d;
    logic                refresh_stb_d;

    // Next-state, timer and strobe decisions for the measurement cycle.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        gate_d        = gate_q;
        range_d       = range_q;
        sticky_d      = sticky_q;
        refresh_stb_d = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                sticky_d = 1'b0;
                if (phase_q == '0) begin
                    // Range is captured once here so later changes only
                    // affect the following measurement.
                    state_d = ST_GATE;
                    gate_d  = gate_load(range_sel_in);
                    range_d = range_sel_in;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_GATE: begin
                if (overflow_in) begin
                    sticky_d = 1'b1;
                end
                if (gate_q == '0) begin
                    state_d = ST_SETTLE;
                    phase_d = SETTLE_LOAD;
                end else begin
                    gate_d = gate_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (phase_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_LATCH: begin
                // Ready is watched from the latch cycle onward; the registered
                // strobe follows the first cycle it is seen high.
                state_d       = ST_REFRESH;
                refresh_stb_d = streamer_ready_in;
            end
            ST_REFRESH: begin
                if (refresh_stb_out) begin
                    state_d = ST_HOLDOFF;
                    phase_d = HOLDOFF_LOAD;
                end else begin
                    refresh_stb_d = streamer_ready_in;
                end
            end
            ST_HOLDOFF: begin
                // The streamer's ready lags the strobe; ignore it here.
                if (phase_q == '0) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (streamer_ready_in) begin
                    if (hold_in) begin
                        state_d = ST_FROZEN;
                    end else begin
                        state_d = ST_CLEAR;
                        phase_d = CLEAR_LOAD;
                    end
                end
            end
            ST_FROZEN: begin
                if (!hold_in) begin
                    state_d = ST_CLEAR;
                    phase_d = CLEAR_LOAD;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                phase_d = CLEAR_LOAD;
            end
        endcase
    end

    // State, timers and registered outputs; reset restarts a full clear.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q         <= ST_CLEAR;
            phase_q         <= CLEAR_LOAD;
            gate_q          <= '0;
            range_q         <= '0;
            sticky_q        <= 1'b0;
            cnt_reset_out   <= 1'b1;
            cnt_enable_out  <= 1'b0;
            latch_stb_out   <= 1'b0;
            refresh_stb_out <= 1'b0;
            range_out       <= '0;
            overflow_out    <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            gate_q          <= gate_d;
            range_q         <= range_d;
            sticky_q        <= sticky_d;
            cnt_reset_out   <= (state_d == ST_CLEAR);
            cnt_enable_out  <= (state_d == ST_GATE);
            latch_stb_out   <= (state_d == ST_LATCH);
            refresh_stb_out <= refresh_stb_d;
            if (state_d == ST_LATCH) begin
                range_out    <= range_q;
                overflow_out <= sticky_q;
            end
        end
    end

endmodule
